mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one port of the dual-port BRAM main memory between NUM_REQ requesters
//  (CPU load/store unit = req 0, debug/loader = req 1, ...). Grants at most one access
//  per cycle, drives the BRAM port, and returns each response to its requester one cycle later.
//  Supports a per-requester lock so read-modify-write sequences run without interleaving.
// PARAMETERS
//  NUM_REQ   2     number of requesters (>=2)
//  ADDR_W    13    byte-address width, = $clog2(MEM_SIZE) of the attached memory
// PORTS
//  clk           in   1              clock
//  rst           in   1              synchronous active-high reset
//  req_valid     in   NUM_REQ        request present
//  req_ready     out  NUM_REQ        request accepted this cycle (one-hot or zero)
//  req_we        in   NUM_REQ        1 = write, 0 = read
//  req_lock      in   NUM_REQ        hold grant after this access
//  req_addr      in   NUM_REQ x ADDR_W  byte address; low 2 bits passed through, ignored by memory
//  req_wdata     in   NUM_REQ x 32   write data
//  req_be        in   NUM_REQ x 4    byte enables, relative to address mod 4
//  rsp_valid     out  NUM_REQ        response for the access accepted last cycle
//  rsp_rdata     out  32             read data (shared bus; qualify with rsp_valid)
//  mem_addr      out  ADDR_W         to memory addr
//  mem_data_i    out  32             to memory data_i
//  mem_data_en   out  4              to memory data_en
//  mem_write_en  out  1              to memory write_en
//  mem_data_o    in   32             from memory data_o (registered, 1-cycle latency)
// BEHAVIOUR
//  - Clock clk; reset rst is synchronous and active-high.
//  - Reset: rsp_valid=0, req_ready=0, mem_write_en=0, state=IDLE, rr pointer=0, pipe valid=0.
//    Reset in LOCKED state returns to IDLE; an access accepted in the reset cycle is dropped.
//  - Grant is combinational: winner w selected from req_valid; req_ready[w]=1,
//    mem_* driven from requester w. No winner: mem_write_en=0, mem_data_en=0, mem_addr=0.
//  - Accepted = req_valid[w] & req_ready[w]. No backpressure on responses; requester must
//    accept rsp_valid when it arrives.
//  - Latency: rsp_valid[w]=1 exactly one cycle after acceptance, rsp_rdata=mem_data_o.
//    Writes also get rsp_valid (ack); rsp_rdata then = pre-write word (read-before-write).
//  - Throughput: one access per cycle, back-to-back, any requester mix.
//  - FSM: IDLE -> LOCKED(w) when accepted access has req_lock[w]=1.
//    LOCKED(w): only w eligible; others see req_ready=0 even if valid.
//    LOCKED(w) -> IDLE when w has an accepted access with req_lock[w]=0.
//    Deasserting req_valid[w] while LOCKED does not release the lock.
//  - Arbitration (IDLE): see CONFIGURATION. Pointer updates only on acceptance.
//  - Response pipe: 1-deep register {valid, grant index}; always overwritten each cycle.
// CONFIGURATION
//  MEMARB_RR_EN defined: round-robin; after accepting w, priority starts at (w+1) mod NUM_REQ,
//    wrapping from NUM_REQ-1 to 0.
//  MEMARB_RR_EN undefined: fixed priority, lowest index wins; rr pointer logic absent.
// STRUCTURE
//  Package mem_arb_pkg: ADDR_W default, typedef arb_state_e {ARB_IDLE, ARB_LOCKED},
//    localparam IDX_W = $clog2(NUM_REQ) helper function.
//  Sub-module rr_priority_pick: req vector + start index -> one-hot grant + index
//    (start forced to 0 for fixed priority).
// TESTING
//  1 Single read: req0 read addr 0x10, mem word 0xDEADBEEF -> req_ready0 same cycle,
//    rsp_valid0=1 next cycle with 0xDEADBEEF, rsp_valid1=0.
//  2 Contention: req0,req1 valid 4 cycles -> RR: grants 0,1,0,1; fixed: 0,0,0,0, req1 starved.
//  3 Byte write: req1 write addr 0x6, be=4'b0100, wdata 0x00AB0000 -> mem_data_en=0100,
//    ack next cycle; later read of 0x4 shows byte 2 = 0xAB, other bytes unchanged.
//  4 Lock: req0 read lock=1, req1 valid -> req1 blocked until req0 write lock=0 accepted;
//    req1 granted the following cycle.
//  5 Reset mid-lock: rst while LOCKED(0) -> next cycle IDLE, rsp_valid=0, req1 grantable.
//  6 Back-to-back: req0 reads 0x0,0x4,0x8 consecutive cycles -> three rsp_valid in a row, in order.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter.
// Holds the default address width, the FSM state type and the index-width helper.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 13;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester-side request/response bundle for the BRAM port arbiter.
// master = requesters, slave = arbiter.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEF
);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ-1:0]             req_lock;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][31:0]       req_wdata;
    logic [NUM_REQ-1:0][3:0]        req_be;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [31:0]                    rsp_rdata;

    modport master (
        output req_valid, req_we, req_lock,
        output req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_lock,
        input  req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Rotating priority picker: first set request at or after start, wrapping.
// Fixed priority is obtained by tying start to zero.
module rr_priority_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   s;
    logic [IW-1:0] k;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        s   = '0;
        k   = '0;
        for (int i = 0; i < N; i++) begin
            s = {1'b0, start} + (IW+1)'(i);
            if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
            k = s[IW-1:0];
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// One BRAM port shared by NUM_REQ requesters, with lock support for RMW.
// Define MEMARB_RR_EN for round-robin; otherwise fixed lowest-index priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    mem_arb_if.slave          bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data_i,
    output logic [3:0]        mem_data_en,
    output logic              mem_write_en,
    input  logic [31:0]       mem_data_o
);

    localparam int IW = idx_w(NUM_REQ);

    localparam logic [0:0] ST_IDLE   = ARB_IDLE;
    localparam logic [0:0] ST_LOCKED = ARB_LOCKED;

    logic [0:0]         state;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      start;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      pipe_idx;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] gnt;
    logic               win;
    logic               pipe_valid;

    // Nothing is granted in the reset cycle, so such accesses are dropped.
    always_comb begin
        eligible = '0;
        if (!rst) begin
            if (state == ST_LOCKED)
                eligible[owner] = bus.req_valid[owner];
            else
                eligible = bus.req_valid;
        end
    end

`ifdef MEMARB_RR_EN
    logic [IW-1:0] rr_ptr;

    assign start = rr_ptr;

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (win)
            rr_ptr <= (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
    end
`else
    assign start = '0;
`endif

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (eligible),
        .start (start),
        .gnt   (gnt),
        .idx   (win_idx),
        .any   (win)
    );

    assign bus.req_ready = gnt;

    always_comb begin
        mem_addr     = '0;
        mem_data_i   = '0;
        mem_data_en  = '0;
        mem_write_en = 1'b0;
        if (win) begin
            mem_addr     = bus.req_addr[win_idx];
            mem_data_i   = bus.req_wdata[win_idx];
            mem_data_en  = bus.req_be[win_idx];
            mem_write_en = bus.req_we[win_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= '0;
            pipe_valid <= 1'b0;
            pipe_idx   <= '0;
        end else begin
            pipe_valid <= win;
            pipe_idx   <= win_idx;
            case (state)
                ST_IDLE: begin
                    if (win && bus.req_lock[win_idx]) begin
                        state <= ST_LOCKED;
                        owner <= win_idx;
                    end
                end
                ST_LOCKED: begin
                    if (win && !bus.req_lock[win_idx])
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (pipe_valid) bus.rsp_valid[pipe_idx] = 1'b1;
    end

    // BRAM output is registered, so it lines up with the response pipe.
    assign bus.rsp_rdata = mem_data_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table plus random traffic
// checked against a behavioural model of arbitration, locking and memory.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int N     = 2;
    localparam int AW    = 13;
    localparam int WORDS = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_init;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data_i;
    logic [31:0]   mem_data_o;
    logic [3:0]    mem_data_en;
    logic          mem_write_en;

    always #5 clk = ~clk;

    mem_arb_if #(.NUM_REQ(N), .ADDR_W(AW)) bus();

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mem_addr     (mem_addr),
        .mem_data_i   (mem_data_i),
        .mem_data_en  (mem_data_en),
        .mem_write_en (mem_write_en),
        .mem_data_o   (mem_data_o)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        if (i == 1) return 32'h1122_3344;
        return {16'hA5A5, 16'(i)};
    endfunction

    // BRAM: registered read, read-before-write, byte-lane write enables
    logic [31:0] bram [0:WORDS-1];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < WORDS; i++) bram[i] <= init_word(i);
        end else begin
            mem_data_o <= bram[mem_addr[AW-1:2]];
            for (int b = 0; b < 4; b++)
                if (mem_write_en && mem_data_en[b])
                    bram[mem_addr[AW-1:2]][8*b +: 8] <= mem_data_i[8*b +: 8];
        end
    end

    typedef struct {
        bit          rst;
        logic [1:0]  v, we, lk;
        logic [AW-1:0] a0, a1;
        logic [31:0] d0, d1;
        logic [3:0]  b0, b1;
        logic [1:0]  rdy, rsp;
        logic        mwe;
        logic [3:0]  mbe;
        bit          crd;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl[$];

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] ref_mem [0:WORDS-1];
    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    bit          pv;
    int          pidx;
    logic [31:0] pdata;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        bit r, logic [1:0] v, logic [1:0] we, logic [1:0] lk,
        logic [AW-1:0] a0, logic [AW-1:0] a1,
        logic [31:0] d0, logic [31:0] d1,
        logic [3:0] b0, logic [3:0] b1,
        logic [1:0] rdy, logic [1:0] rsp,
        logic mwe, logic [3:0] mbe,
        bit crd, logic [31:0] erd);
        vec_t t;
        t.rst = r;  t.v = v;  t.we = we;  t.lk = lk;
        t.a0 = a0;  t.a1 = a1; t.d0 = d0; t.d1 = d1;
        t.b0 = b0;  t.b1 = b1; t.rdy = rdy; t.rsp = rsp;
        t.mwe = mwe; t.mbe = mbe; t.crd = crd; t.erd = erd;
        return t;
    endfunction

    function automatic int model_pick(input bit r, input logic [1:0] v);
        if (r) return -1;
        if (m_locked) return v[m_owner] ? m_owner : -1;
`ifdef MEMARB_RR_EN
        for (int k = 0; k < N; k++)
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
        for (int k = 0; k < N; k++)
            if (v[k]) return k;
`endif
        return -1;
    endfunction

    task automatic model_update(input vec_t t, input int w);
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
        if (t.rst) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; pv = 0;
        end else if (w >= 0) begin
            a  = (w == 0) ? t.a0 : t.a1;
            d  = (w == 0) ? t.d0 : t.d1;
            be = (w == 0) ? t.b0 : t.b1;
            pv = 1; pidx = w;
            pdata = ref_mem[a[AW-1:2]];
            if (t.we[w])
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a[AW-1:2]][8*b +: 8] = d[8*b +: 8];
            m_ptr    = (w + 1) % N;
            m_locked = t.lk[w];
            m_owner  = w;
        end else begin
            pv = 0;
        end
    endtask

    task automatic drive(input vec_t t);
        rst                = t.rst;
        bus.req_valid      = t.v;
        bus.req_we         = t.we;
        bus.req_lock       = t.lk;
        bus.req_addr[0]    = t.a0;
        bus.req_addr[1]    = t.a1;
        bus.req_wdata[0]   = t.d0;
        bus.req_wdata[1]   = t.d1;
        bus.req_be[0]      = t.b0;
        bus.req_be[1]      = t.b1;
    endtask

    task automatic run_cycle(input vec_t t, input bit use_tbl);
        int         w;
        logic [1:0] erdy, ersp;
        logic       emwe;
        logic [3:0] embe;
        drive(t);
        #4;
        w = model_pick(t.rst, t.v);
        if (use_tbl) begin
            erdy = t.rdy; ersp = t.rsp; emwe = t.mwe; embe = t.mbe;
        end else begin
            erdy = (w >= 0) ? 2'(1 << w) : 2'b00;
            ersp = pv ? 2'(1 << pidx) : 2'b00;
            emwe = (w >= 0) ? t.we[w] : 1'b0;
            embe = (w < 0) ? 4'h0 : (w == 0) ? t.b0 : t.b1;
        end
        chk("req_ready", bus.req_ready, erdy);
        chk("rsp_valid", bus.rsp_valid, ersp);
        chk("mem_write_en", mem_write_en, emwe);
        chk("mem_data_en", mem_data_en, embe);
        if (pv && ersp != 2'b00) chk("rsp_rdata", bus.rsp_rdata, pdata);
        if (use_tbl && t.crd) chk("rdata_vec", bus.rsp_rdata, t.erd);
        if (!use_tbl && w >= 0)
            chk("mem_addr", mem_addr, (w == 0) ? t.a0 : t.a1);
        model_update(t, w);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit         rr;
        logic [1:0] g_a, g_b;
        vec_t       t;
`ifdef MEMARB_RR_EN
        rr = 1;
`else
        rr = 0;
`endif
        g_a = rr ? 2'b10 : 2'b01;
        g_b = 2'b01;

        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        m_locked = 0; m_owner = 0; m_ptr = 0; pv = 0; pidx = 0; pdata = '0;

        t = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(t);
        mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;

        // rst,v,we,lk,a0,a1,d0,d1,b0,b1 | rdy,rsp,mwe,mbe,crd,erd
        tbl.push_back(mk(1, 2'b11, 2'b11, 0, 0, 0, 32'h1, 32'h2, 4'hF, 4'hF,
                         0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2'b01, 0, 0, 13'h10, 0, 0, 0, 4'hF, 4'hF,
                         2'b01, 0, 0, 4'hF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'hF,
                         0, 2'b01, 0, 0, 1, 32'hDEAD_BEEF));
        tbl.push_back(mk(0, 2'b10, 0, 0, 0, 13'h4, 0, 0, 4'hF, 4'hF,
                         2'b10, 0, 0, 4'hF, 0, 0));
        tbl.push_back(mk(0, 2'b11, 0, 0, 13'h0, 13'h4, 0, 0, 4'hF, 4'hF,
                         2'b01, 2'b10, 0, 4'hF, 0, 0));
        tbl.push_back(mk(0, 2'b11, 0, 0, 13'h0, 13'h4, 0, 0, 4'hF, 4'hF,
                         g_a, 2'b01, 0, 4'hF, 0, 0));
        tbl.push_back(mk(0, 2'b11, 0, 0, 13'h0, 13'h4, 0, 0, 4'hF, 4'hF,
                         g_b, g_a, 0, 4'hF, 0, 0));
        tbl.push_back(mk(0, 2'b11, 0, 0, 13'h0, 13'h4, 0, 0, 4'hF, 4'hF,
                         g_a, 2'b01, 0, 4'hF, 0, 0));
        tbl.push_back(mk(0, 2'b10, 2'b10, 0, 0, 13'h6, 0, 32'h00AB_0000,
                         4'hF, 4'b0100, 2'b10, g_a, 1, 4'b0100, 0, 0));
        tbl.push_back(mk(0, 2'b01, 0, 0, 13'h4, 0, 0, 0, 4'hF, 4'hF,
                         2'b01, 2'b10, 0, 4'hF, 1, 32'h1122_3344));
        tbl.push_back(mk(0, 2'b10, 0, 0, 0, 13'h0, 0, 0, 4'hF, 4'hF,
                         2'b10, 2'b01, 0, 4'hF, 1, 32'h11AB_3344));
        tbl.push_back(mk(0, 2'b11, 0, 2'b01, 13'h8, 13'hC, 0, 0, 4'hF, 4'hF,
                         2'b01, 2'b10, 0, 4'hF, 0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 0, 13'h8, 13'hC, 0, 0, 4'hF, 4'hF,
                         0, 2'b01, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2'b11, 0, 2'b01, 13'h8, 13'hC, 0, 0, 4'hF, 4'hF,
                         2'b01, 0, 0, 4'hF, 0, 0));
        tbl.push_back(mk(0, 2'b11, 2'b01, 0, 13'h8, 13'hC, 32'hCAFE_F00D, 0,
                         4'hF, 4'hF, 2'b01, 2'b01, 1, 4'hF, 0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 0, 13'h8, 13'hC, 0, 0, 4'hF, 4'hF,
                         2'b10, 2'b01, 0, 4'hF, 1, 32'hA5A5_0002));
        tbl.push_back(mk(0, 2'b01, 0, 2'b01, 13'h0, 0, 0, 0, 4'hF, 4'hF,
                         2'b01, 2'b10, 0, 4'hF, 0, 0));
        tbl.push_back(mk(1, 2'b11, 2'b11, 2'b01, 13'h0, 13'h4, 0, 0,
                         4'hF, 4'hF, 0, 2'b01, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2'b10, 0, 0, 0, 13'h4, 0, 0, 4'hF, 4'hF,
                         2'b10, 0, 0, 4'hF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'hF,
                         0, 2'b10, 0, 0, 1, 32'h11AB_3344));
        tbl.push_back(mk(0, 2'b01, 0, 0, 13'h0, 0, 0, 0, 4'hF, 4'hF,
                         2'b01, 0, 0, 4'hF, 0, 0));
        tbl.push_back(mk(0, 2'b01, 0, 0, 13'h4, 0, 0, 0, 4'hF, 4'hF,
                         2'b01, 2'b01, 0, 4'hF, 1, 32'hA5A5_0000));
        tbl.push_back(mk(0, 2'b01, 0, 0, 13'h8, 0, 0, 0, 4'hF, 4'hF,
                         2'b01, 2'b01, 0, 4'hF, 1, 32'h11AB_3344));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'hF,
                         0, 2'b01, 0, 0, 1, 32'hCAFE_F00D));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'hF,
                         0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) run_cycle(tbl[i], 1'b1);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            t.rst = ($urandom_range(0, 49) == 0);
            t.v   = 2'($urandom_range(0, 3));
            t.we  = 2'($urandom_range(0, 3));
            t.lk  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            t.a0  = AW'($urandom_range(0, 63));
            t.a1  = AW'($urandom_range(0, 63));
            t.d0  = $urandom;
            t.d1  = $urandom;
            t.b0  = 4'($urandom_range(0, 15));
            t.b1  = 4'($urandom_range(0, 15));
            t.rdy = 0; t.rsp = 0; t.mwe = 0; t.mbe = 0;
            t.crd = 0; t.erd = 0;
            run_cycle(t, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
